// File: rtl/sync_handshake_rx_if.sv
// Bundle between the toggle-CDC receiver and its neighbours: the synchronized request
// and held data bus from the source side, and the valid/ready word handshake plus status.
interface sync_handshake_rx_if #(
    parameter int DW = 32
);
    // Handshake: a word moves on every rising clock edge where DVALID & DREADY are both 1.
    // DVALID, once high, holds with DOUT unchanged until that edge; DREADY may toggle freely.
    logic          REQ_SYNC;
    logic [DW-1:0] DIN;
    logic [DW-1:0] DOUT;
    logic          DVALID;
    logic          DREADY;
    logic          ACK_TGL;
    logic          BUSY;
    logic          PROTO_ERR;
    logic [7:0]    XFER_CNT;
    logic [1:0]    STATE;

    modport master (
        output REQ_SYNC, DIN, DREADY,
        input  DOUT, DVALID, ACK_TGL, BUSY, PROTO_ERR, XFER_CNT, STATE
    );

    modport slave (
        input  REQ_SYNC, DIN, DREADY,
        output DOUT, DVALID, ACK_TGL, BUSY, PROTO_ERR, XFER_CNT, STATE
    );
endinterface

// File: rtl/sync_handshake_rx.sv
// Destination side of a toggle request/acknowledge CDC transfer: detects the request
// toggle, waits SETTLE cycles, captures the held bus and hands it on with valid/ready.
module sync_handshake_rx #(
    parameter int DW     = 32,
    parameter int SETTLE = 1
) (
    input  logic              CP,
    input  logic              RST,
    sync_handshake_rx_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [2:0] SETTLE_CNT = 3'(SETTLE);
    localparam bit         NO_SETTLE  = (SETTLE == 0);

    state_t        state;
    state_t        state_nxt;
    logic          req_d;
    logic          req_edge;
    logic [2:0]    cnt;
    logic [DW-1:0] dout_q;
    logic          dvalid_q;
    logic          ack_q;
    logic          err_q;
    logic [7:0]    xfer_q;

    logic          capture;
    logic          accept;
    logic          load_cnt;
    logic          err_hit;

    assign req_edge = bus.REQ_SYNC ^ req_d;

    always_ff @(posedge CP) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_edge) begin
                    state_nxt = NO_SETTLE ? ST_HOLD : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == 3'd1) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.DREADY) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Edges seen outside IDLE only raise the error flag; the transfer in flight carries on.
    always_comb begin
        capture  = 1'b0;
        accept   = 1'b0;
        load_cnt = 1'b0;
        err_hit  = 1'b0;
        case (state)
            ST_IDLE: begin
                capture  = req_edge & NO_SETTLE;
                load_cnt = req_edge & ~NO_SETTLE;
            end
            ST_SETTLE: begin
                capture = (cnt == 3'd1);
                err_hit = req_edge;
            end
            ST_HOLD: begin
                accept  = bus.DREADY;
                err_hit = req_edge;
            end
            default: begin
                capture  = 1'b0;
                accept   = 1'b0;
                load_cnt = 1'b0;
                err_hit  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            req_d    <= 1'b0;
            cnt      <= 3'd0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            xfer_q   <= 8'd0;
        end else begin
            req_d <= bus.REQ_SYNC;

            if (load_cnt) begin
                cnt <= SETTLE_CNT;
            end else if (state == ST_SETTLE) begin
                cnt <= cnt - 3'd1;
            end

            if (capture) begin
                dout_q   <= bus.DIN;
                dvalid_q <= 1'b1;
            end else if (accept) begin
                dvalid_q <= 1'b0;
            end

            // Each accepted word flips the acknowledge back to the source exactly once.
            if (accept) begin
                ack_q  <= ~ack_q;
                xfer_q <= xfer_q + 8'd1;
            end

            if (err_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.DOUT      = dout_q;
    assign bus.DVALID    = dvalid_q;
    assign bus.ACK_TGL   = ack_q;
    assign bus.BUSY      = (state != ST_IDLE);
    assign bus.PROTO_ERR = err_q;
    assign bus.XFER_CNT  = xfer_q;
    assign bus.STATE     = state;
endmodule

// File: tb/tb_sync_handshake_rx.sv
// Bench for sync_handshake_rx at SETTLE 1, 0 and 7: directed scenarios with literal
// expectations, then random traffic against a cycle-count reference model and word queue.
module tb_sync_handshake_rx;
  localparam int DW = 32;
  localparam int NI = 3;
  localparam int ST [NI] = '{1, 0, 7};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic          req    [NI];
  logic [DW-1:0] din    [NI];
  logic          dready [NI];

  logic [DW-1:0] dout_w   [NI];
  logic          dvalid_w [NI];
  logic          ack_w    [NI];
  logic          busy_w   [NI];
  logic          err_w    [NI];
  logic [7:0]    xcnt_w   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sync_handshake_rx_if #(.DW(DW)) bus ();
    assign bus.REQ_SYNC = req[g];
    assign bus.DIN      = din[g];
    assign bus.DREADY   = dready[g];
    assign dout_w[g]    = bus.DOUT;
    assign dvalid_w[g]  = bus.DVALID;
    assign ack_w[g]     = bus.ACK_TGL;
    assign busy_w[g]    = bus.BUSY;
    assign err_w[g]     = bus.PROTO_ERR;
    assign xcnt_w[g]    = bus.XFER_CNT;

    sync_handshake_rx #(.DW(DW), .SETTLE(ST[g])) u_dut (
      .CP  (clk),
      .RST (rst),
      .bus (bus.slave)
    );
  end

  // Reference model: tracks only "busy since edge", the cycle index within the
  // transfer, and the architectural outputs.
  logic          m_prev  [NI];
  logic          m_busy  [NI];
  logic          m_valid [NI];
  logic          m_ack   [NI];
  logic          m_err   [NI];
  logic [DW-1:0] m_dout  [NI];
  logic [7:0]    m_cnt   [NI];
  int            m_age   [NI];

  always @(posedge clk) begin : model_step
    logic e, nb, nv, na, ne;
    logic [DW-1:0] nd;
    logic [7:0] nc;
    int ng;
    for (int i = 0; i < NI; i++) begin
      nb = m_busy[i]; nv = m_valid[i]; na = m_ack[i]; ne = m_err[i];
      nd = m_dout[i]; nc = m_cnt[i]; ng = m_age[i];
      if (rst) begin
        nb = 1'b0; nv = 1'b0; na = 1'b0; ne = 1'b0; nd = '0; nc = 8'd0; ng = 0;
      end else begin
        e = req[i] ^ m_prev[i];
        if (nb !== 1'b1) begin
          if (e) begin
            nb = 1'b1;
            ng = 0;
            if (ST[i] == 0) begin nd = din[i]; nv = 1'b1; end
          end
        end else begin
          if (e) ne = 1'b1;
          ng = ng + 1;
          if (nv) begin
            if (dready[i]) begin nv = 1'b0; na = ~na; nc = nc + 8'd1; nb = 1'b0; end
          end else if (ng == ST[i]) begin
            nd = din[i]; nv = 1'b1;
          end
        end
      end
      m_prev[i]  <= rst ? 1'b0 : req[i];
      m_busy[i]  <= nb;
      m_valid[i] <= nv;
      m_ack[i]   <= na;
      m_err[i]   <= ne;
      m_dout[i]  <= nd;
      m_cnt[i]   <= nc;
      m_age[i]   <= ng;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = 0;
  bit chk_en  = 1'b0;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string name, input int idx, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s inst=%0d (SETTLE=%0d) t=%0t: got %h expected %h",
                 name, idx, ST[idx], $time, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [DW-1:0] w;
    for (int i = 0; i < NI; i++) begin
      chk("dvalid", i, DW'(dvalid_w[i]), DW'(m_valid[i]));
      chk("dout", i, dout_w[i], m_dout[i]);
      chk("ack_tgl", i, DW'(ack_w[i]), DW'(m_ack[i]));
      chk("busy", i, DW'(busy_w[i]), DW'(m_busy[i]));
      chk("proto_err", i, DW'(err_w[i]), DW'(m_err[i]));
      chk("xfer_cnt", i, DW'(xcnt_w[i]), DW'(m_cnt[i]));
      if (i == cur && dvalid_w[i] === 1'b1 && dready[i] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra inst=%0d t=%0t: got word %h expected none", i, $time, dout_w[i]);
        end else begin
          w = exp_q.pop_front();
          chk("sb_word", i, dout_w[i], w);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk_en = 1'b1;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (m_busy[cur] === 1'b1 && g < 200) begin
      tick();
      g++;
    end
    n_tests++;
    if (g >= 200) begin
      n_fail++;
      $display("FAIL idle_timeout inst=%0d: still busy after %0d cycles, required idle", cur, g);
    end
  endtask

  task automatic send(input logic [DW-1:0] w);
    din[cur] = w;
    req[cur] = ~req[cur];
    exp_q.push_back(w);
  endtask

  task automatic run_inst(input int i);
    logic [DW-1:0] w;
    cur = i;
    dready[i] = 1'b1;
    reset_dut();

    // basic transfer, ready high
    send(32'hA5A5_0001);
    repeat (ST[i]) tick();
    chk("basic_pre_valid", i, DW'(dvalid_w[i]), 32'd0);
    tick();
    chk("basic_valid", i, DW'(dvalid_w[i]), 32'd1);
    chk("basic_dout", i, dout_w[i], 32'hA5A5_0001);
    chk("basic_ack_before", i, DW'(ack_w[i]), 32'd0);
    tick();
    chk("basic_ack_after", i, DW'(ack_w[i]), 32'd1);
    chk("basic_valid_drop", i, DW'(dvalid_w[i]), 32'd0);
    chk("basic_cnt", i, DW'(xcnt_w[i]), 32'd1);

    // backpressure for 10 cycles
    dready[i] = 1'b0;
    w = $urandom;
    send(w);
    repeat (ST[i] + 1) tick();
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", i, DW'(dvalid_w[i]), 32'd1);
      chk("bp_dout", i, dout_w[i], w);
      chk("bp_ack", i, DW'(ack_w[i]), 32'd1);
      tick();
    end
    dready[i] = 1'b1;
    tick();
    chk("bp_ack_after", i, DW'(ack_w[i]), 32'd0);
    chk("bp_cnt", i, DW'(xcnt_w[i]), 32'd2);

    // protocol error: second toggle in HOLD
    dready[i] = 1'b0;
    send(32'h0BAD_F00D);
    repeat (ST[i] + 1) tick();
    req[i] = ~req[i];
    tick();
    chk("perr_set", i, DW'(err_w[i]), 32'd1);
    chk("perr_dout", i, dout_w[i], 32'h0BAD_F00D);
    dready[i] = 1'b1;
    tick();
    chk("perr_cnt", i, DW'(xcnt_w[i]), 32'd3);
    for (int k = 0; k < ST[i] + 3; k++) begin
      chk("perr_no_second", i, DW'(dvalid_w[i]), 32'd0);
      tick();
    end
    chk("perr_sticky", i, DW'(err_w[i]), 32'd1);

    // reset while holding a word; REQ_SYNC is 1 afterwards and starts a new transfer
    dready[i] = 1'b0;
    send(32'h1234_5678);
    repeat (ST[i] + 1) tick();
    chk("rst_pre_valid", i, DW'(dvalid_w[i]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("rst_valid", i, DW'(dvalid_w[i]), 32'd0);
    chk("rst_dout", i, dout_w[i], 32'd0);
    chk("rst_ack", i, DW'(ack_w[i]), 32'd0);
    chk("rst_err", i, DW'(err_w[i]), 32'd0);
    chk("rst_cnt", i, DW'(xcnt_w[i]), 32'd0);
    chk("rst_busy", i, DW'(busy_w[i]), 32'd0);
    exp_q.push_back(din[i]);
    dready[i] = 1'b1;
    tick();
    chk("post_rst_edge_busy", i, DW'(busy_w[i]), 32'd1);
    wait_idle();
    tick();
    chk("post_rst_cnt", i, DW'(xcnt_w[i]), 32'd1);

    // random traffic, occasional stray toggles
    for (int k = 0; k < 300; k++) begin
      dready[i] = 1'($urandom_range(0, 1));
      if (m_busy[i] !== 1'b1) begin
        if ($urandom_range(0, 2) == 0) send($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        req[i] = ~req[i];
      end
      tick();
    end
    dready[i] = 1'b1;
    wait_idle();
    tick();
    chk("rand_drained", i, 32'(exp_q.size()), 32'd0);

    // 256 back-to-back transfers wrap the counter
    req[i] = 1'b0;
    reset_dut();
    for (int n = 0; n < 256; n++) begin
      wait_idle();
      send(n[0] ? (32'h5555_5555 ^ 32'(n)) : (32'hAAAA_AAAA ^ 32'(n)));
      tick();
    end
    wait_idle();
    tick();
    chk("wrap_cnt", i, DW'(xcnt_w[i]), 32'd0);
    chk("wrap_ack", i, DW'(ack_w[i]), 32'd0);
    chk("wrap_drained", i, 32'(exp_q.size()), 32'd0);
    dready[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0;
      din[i] = '0;
      dready[i] = 1'b0;
    end
    for (int i = 0; i < NI; i++) run_inst(i);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
    $fatal(1);
  end
endmodule

// File: doc/sync_handshake_rx.md
# sync_handshake_rx

Destination-domain receiver for a toggle-based request/acknowledge CDC bus transfer. It sits directly downstream of the two-flop `SYNC_CELL` synchronizer: it consumes the synchronized request toggle and captures the multi-bit data bus, which the source holds stable. It then presents the word to the local consumer through a valid/ready handshake and returns an acknowledge toggle to the source domain, where another `SYNC_CELL` synchronizes it.

## Interface
- `DW`, 32: data bus width.
- `SETTLE`, 1: extra destination cycles between toggle detection and data capture, legal range 0..7.

- `CP` in 1: destination clock.
- `RST` in 1: synchronous, active-high reset.
- `REQ_SYNC` in 1: request toggle, already synchronized (`SYNC_CELL.Q`).
- `DIN` in `DW`: source data bus; the source holds it stable from its toggle until it sees `ACK_TGL` change.
- `DOUT` out `DW`: captured word.
- `DVALID` out 1: `DOUT` holds an unaccepted word.
- `DREADY` in 1: consumer accepts the word when `DVALID & DREADY`.
- `ACK_TGL` out 1: acknowledge toggle to the source domain.
- `BUSY` out 1: state is not IDLE.
- `PROTO_ERR` out 1: sticky flag, set when a request toggle arrives while not IDLE.
- `XFER_CNT` out 8: completed transfers, wraps 255→0.

## Operation
- `req_d` registers `REQ_SYNC` every cycle.
- `edge = REQ_SYNC ^ req_d`.
- State machine states: IDLE, SETTLE, HOLD.
- IDLE, `edge`, `SETTLE == 0`: `DOUT <= DIN`, `DVALID <= 1`, go to HOLD.
- IDLE, `edge`, `SETTLE > 0`: `cnt <= SETTLE`, go to SETTLE.
- IDLE, no edge: hold all registers.
- SETTLE: `cnt <= cnt - 1`. When `cnt == 1`: `DOUT <= DIN`, `DVALID <= 1`, go to HOLD.
- HOLD: `DOUT` and `DVALID` are stable.
- HOLD, `DREADY == 1`: `DVALID <= 0`, `ACK_TGL <= ~ACK_TGL`, `XFER_CNT <= XFER_CNT + 1`, go to IDLE.
- `edge` in SETTLE or HOLD:
  - `PROTO_ERR <= 1`.
  - The edge is dropped, not queued.
  - The current transfer completes normally.
- `PROTO_ERR` clears only on `RST`.
- `DOUT` is never modified outside the capture cycle.
- `BUSY = (state != IDLE)`, combinational from the state register.

## Timing
- Cycle 0 is the first cycle in which `REQ_SYNC` differs from `req_d`.
- `DVALID` rises in cycle `SETTLE + 1`.
- `DOUT` is valid in that same cycle.
- If `DREADY` is high in the first `DVALID` cycle, `DVALID` falls and `ACK_TGL` toggles in the following cycle. Minimum occupancy is `SETTLE + 2` cycles.
- Back-to-back: a new edge arriving in the cycle after the return to IDLE is accepted normally.
- `DREADY` is ignored outside HOLD.
- `DVALID` never deasserts without an accept.
- Reset values, applied on any cycle including mid-transfer:
  - state IDLE, `cnt` 0
  - `req_d` 0, `DVALID` 0, `DOUT` 0
  - `ACK_TGL` 0, `PROTO_ERR` 0, `XFER_CNT` 0
  - `BUSY` 0
- A reset in HOLD discards the word without toggling the acknowledge. The source domain is reset together with this block.
- If `REQ_SYNC` is 1 in the first cycle after reset, it is an edge and starts a transfer.

## Test plan
- Basic transfer, `SETTLE=1`, `DREADY` tied high:
  - Stimulus: `DIN=0xA5A5_0001`, toggle `REQ_SYNC` 0→1.
  - Response: `DVALID` in cycle 2 with `DOUT=0xA5A5_0001`; `ACK_TGL` 0→1 in cycle 3; `XFER_CNT=1`.
- Backpressure:
  - Stimulus: `DREADY` held low for 10 cycles.
  - Response: `DVALID` and `DOUT` stable throughout; `ACK_TGL` unchanged; toggle occurs one cycle after `DREADY` rises.
- `SETTLE=0` and `SETTLE=7`: `DVALID` at cycle 1 and cycle 8 respectively. `DIN` changed in cycle 0 is captured only for `SETTLE=0` at the edge ending cycle 0.
- Protocol error:
  - Stimulus: second `REQ_SYNC` toggle while in HOLD.
  - Response: `PROTO_ERR=1` next cycle; first word still delivered; no second `DVALID`; `XFER_CNT` increments once.
- Reset mid-HOLD: assert `RST` for 1 cycle. All outputs at reset values next cycle, no `ACK_TGL` toggle, `PROTO_ERR` cleared.
- Wrap: 256 back-to-back transfers with alternating `DIN` patterns. Every word delivered in order; `XFER_CNT` returns to 0; `ACK_TGL` ends at 0.
